// File: rtl/mem_wb_pipe_pkg.sv
// mem_wb_pipe_pkg: default widths and payload layout shared by the MEM->WB stage
package mem_wb_pipe_pkg;
  localparam int MEM_WB_DATA_W = 32;
  localparam int MEM_WB_REG_ADDR_W = 5;
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic [MEM_WB_DATA_W-1:0] aluOut;
    logic [MEM_WB_DATA_W-1:0] dmOut;
    logic [MEM_WB_REG_ADDR_W-1:0] writeReg;
  } memWbPayload_t;
endpackage

// File: rtl/mem_wb_pipe_skid_buf.sv
// skid_buf: 2-entry FIFO valid/ready buffer with registered inReady and synchronous flush
module skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         inValid,
  output logic         inReady,
  input  logic [W-1:0] inData,
  output logic         outValid,
  input  logic         outReady,
  output logic [W-1:0] outData
);
  logic skidValid, accept, drain, advance, nextMainValid, nextSkidValid;
  logic [W-1:0] skidData, nextMainData, nextSkidData;
  always_comb begin
    accept = inValid & inReady;
    drain = outValid & outReady;
    advance = !outValid | drain;
    nextMainValid = advance ? (skidValid | accept) : outValid;
    nextMainData = advance ? (skidValid ? skidData : (accept ? inData : outData)) : outData;
    nextSkidValid = advance ? (skidValid & accept) : (skidValid | accept);
    nextSkidData = (accept & (skidValid | !advance)) ? inData : skidData;
  end
  // inReady mirrors the next skid state, so an accept can never find the skid occupied
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid <= 1'b0;
      skidValid <= 1'b0;
      outData <= '0;
      skidData <= '0;
      inReady <= 1'b1;
    end else if (flush) begin
      outValid <= 1'b0;
      skidValid <= 1'b0;
      inReady <= 1'b1;
    end else begin
      outValid <= nextMainValid;
      skidValid <= nextSkidValid;
      outData <= nextMainData;
      skidData <= nextSkidData;
      inReady <= !nextSkidValid;
    end
  end
endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM->WB stage with skid buffer, regwrite gating and result mux
// Define MEM_WB_PERF_EN to add retire_cnt/stall_cnt performance counters.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int DATA_W = MEM_WB_DATA_W,
  parameter int REG_ADDR_W = MEM_WB_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  regwriteM,
  input  logic                  memtoregM,
  input  logic [DATA_W-1:0]     alu_outM,
  input  logic [DATA_W-1:0]     dm_outM,
  input  logic [REG_ADDR_W-1:0] write_regM,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  regwriteW,
  output logic                  memtoregW,
  output logic [DATA_W-1:0]     alu_outW,
  output logic [DATA_W-1:0]     dm_outW,
  output logic [REG_ADDR_W-1:0] write_regW,
  output logic [DATA_W-1:0]     resultW
`ifdef MEM_WB_PERF_EN
  ,
  output logic [31:0]           retire_cnt,
  output logic [31:0]           stall_cnt
`endif
);
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic [DATA_W-1:0] aluOut;
    logic [DATA_W-1:0] dmOut;
    logic [REG_ADDR_W-1:0] writeReg;
  } payload_t;
  payload_t inPay, outPay;
  assign inPay = {regwriteM, memtoregM, alu_outM, dm_outM, write_regM};
  skid_buf #(.W($bits(payload_t))) u_skid (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .inValid(in_valid),
    .inReady(in_ready),
    .inData(inPay),
    .outValid(out_valid),
    .outReady(out_ready),
    .outData(outPay)
  );
  // writes to r0 are architecturally discarded
  assign regwriteW = out_valid & outPay.regwrite & (|outPay.writeReg);
  assign memtoregW = outPay.memtoreg;
  assign alu_outW = outPay.aluOut;
  assign dm_outW = outPay.dmOut;
  assign write_regW = outPay.writeReg;
  assign resultW = outPay.memtoreg ? outPay.dmOut : outPay.aluOut;
`ifdef MEM_WB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid & out_ready & (regwriteW | memtoregW)) retire_cnt <= retire_cnt + 32'd1;
      if (out_valid & !out_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed and randomised checks of mem_wb_pipe against a FIFO reference
module tb_mem_wb_pipe;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, regwriteM = 0, memtoregM = 0, out_ready = 0;
  logic [31:0] alu_outM = 0, dm_outM = 0;
  logic [4:0] write_regM = 0;
  logic in_ready, out_valid, regwriteW, memtoregW;
  logic [31:0] alu_outW, dm_outW, resultW;
  logic [4:0] write_regW;
`ifdef MEM_WB_PERF_EN
  logic [31:0] retire_cnt, stall_cnt;
  int unsigned mRetire = 0, mStall = 0;
`endif
  typedef struct {
    logic rw;
    logic mt;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [4:0] rd;
  } ent_t;
  ent_t q[$];
  logic [31:0] seen[$];
  int total = 0, passed = 0;

  mem_wb_pipe dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .regwriteM(regwriteM), .memtoregM(memtoregM), .alu_outM(alu_outM), .dm_outM(dm_outM),
    .write_regM(write_regM), .out_valid(out_valid), .out_ready(out_ready), .regwriteW(regwriteW),
    .memtoregW(memtoregW), .alu_outW(alu_outW), .dm_outW(dm_outW), .write_regW(write_regW),
    .resultW(resultW)
`ifdef MEM_WB_PERF_EN
    , .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // reference: a 2-deep FIFO; the stage is ready whenever fewer than two entries are held
  always @(posedge clk) begin
    automatic bit acc = in_valid && q.size() < 2;
    automatic bit drn = q.size() > 0 && out_ready;
    automatic ent_t e = '{regwriteM, memtoregM, alu_outM, dm_outM, write_regM};
`ifdef MEM_WB_PERF_EN
    if (reset) begin
      mRetire = 0;
      mStall = 0;
    end else begin
      if (drn && ((q[0].rw && q[0].rd != 0) || q[0].mt)) mRetire++;
      if (q.size() > 0 && !out_ready) mStall++;
    end
`endif
    if (!reset && out_valid && out_ready) seen.push_back(resultW);
    if (reset || flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("in_ready", 32'(in_ready), 32'(q.size() < 2));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("alu_outW", alu_outW, q[0].alu);
        check("dm_outW", dm_outW, q[0].dm);
        check("write_regW", 32'(write_regW), 32'(q[0].rd));
        check("memtoregW", 32'(memtoregW), 32'(q[0].mt));
        check("regwriteW", 32'(regwriteW), 32'(q[0].rw && q[0].rd != 0));
        check("resultW", resultW, q[0].mt ? q[0].dm : q[0].alu);
      end else check("regwriteW_idle", 32'(regwriteW), 32'd0);
`ifdef MEM_WB_PERF_EN
      check("retire_cnt", retire_cnt, mRetire);
      check("stall_cnt", stall_cnt, mStall);
`endif
    end
  end

  task automatic step(input logic v, input logic rw, input logic mt, input logic [31:0] alu,
                      input logic [31:0] dm, input logic [4:0] rd, input logic ordy, input logic fl);
    in_valid = v; regwriteM = rw; memtoregM = mt; alu_outM = alu; dm_outM = dm;
    write_regM = rd; out_ready = ordy; flush = fl;
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] alu, input logic ordy);
    step(1, 1, 0, alu, 32'h0, 5'd3, ordy, 0);
  endtask

  task automatic idle(input logic ordy);
    step(0, 0, 0, 32'h0, 32'h0, 5'd0, ordy, 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_alu_outW"}, alu_outW, 32'd0);
    check({tag, "_dm_outW"}, dm_outW, 32'd0);
    check({tag, "_resultW"}, resultW, 32'd0);
    check({tag, "_write_regW"}, 32'(write_regW), 32'd0);
    check({tag, "_regwriteW"}, 32'(regwriteW), 32'd0);
  endtask

  initial begin
    // reset held two cycles with a live input
    step(1, 1, 1, 32'h77, 32'h88, 5'd9, 1, 0);
    @(negedge clk);
    check_cleared("reset");
    reset = 0;
    // streaming at full rate
    push(32'h10, 1);
    check("stream_first_valid", 32'(out_valid), 32'd1);
    check("stream_first_alu", alu_outW, 32'h10);
    check("stream_regwrite", 32'(regwriteW), 32'd1);
    push(32'h20, 1);
    push(32'h30, 1);
    idle(1);
    check("stream_count", seen.size(), 32'd3);
    if (seen.size() == 3) begin
      check("stream_0", seen[0], 32'h10);
      check("stream_1", seen[1], 32'h20);
      check("stream_2", seen[2], 32'h30);
    end
    // back-pressure: two entries held, third stall cycle idle
    seen.delete();
    push(32'h40, 0);
    push(32'h50, 0);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_head", alu_outW, 32'h40);
    idle(0);
    check("bp_head_stable", alu_outW, 32'h40);
    idle(1);
    idle(1);
    check("bp_count", seen.size(), 32'd2);
    if (seen.size() == 2) begin
      check("bp_0", seen[0], 32'h40);
      check("bp_1", seen[1], 32'h50);
    end
    check("bp_empty", 32'(out_valid), 32'd0);
    // flush while full with a live input
    seen.delete();
    push(32'h70, 0);
    push(32'h80, 0);
    step(1, 1, 0, 32'hBAD, 32'h0, 5'd3, 0, 1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    idle(1);
    idle(1);
    check("flush_nothing_out", seen.size(), 32'd0);
    // zero destination and memtoreg
    step(1, 1, 0, 32'h55, 32'h0, 5'd0, 0, 0);
    check("r0_regwrite", 32'(regwriteW), 32'd0);
    idle(1);
    step(1, 1, 1, 32'h4, 32'hDEADBEEF, 5'd7, 0, 0);
    check("mtr_result", resultW, 32'hDEADBEEF);
    check("mtr_regwrite", 32'(regwriteW), 32'd1);
    idle(1);
    // randomised traffic against the reference
    for (int i = 0; i < 200; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    // reset mid-stall discards both entries
    push(32'h90, 0);
    push(32'hA0, 0);
    reset = 1;
    idle(0);
    check_cleared("midreset");
    reset = 0;
    // 4 retires, 3 stall cycles
    seen.delete();
    step(1, 1, 0, 32'hA1, 32'h0, 5'd5, 0, 0);
    step(1, 1, 0, 32'hA2, 32'h0, 5'd5, 0, 0);
    idle(0);
    idle(0);
    idle(1);
    step(1, 1, 0, 32'hA3, 32'h0, 5'd5, 1, 0);
    step(1, 1, 0, 32'hA4, 32'h0, 5'd5, 1, 0);
    idle(1);
    check("perf_seq_count", seen.size(), 32'd4);
`ifdef MEM_WB_PERF_EN
    check("perf_retire", retire_cnt, 32'd4);
    check("perf_stall", stall_cnt, 32'd3);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
